// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: FSM state encoding, opcode map
// and opcode classification helpers.
package acc_cpu_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_STA = 4'h2,
      OP_ADD = 4'h3,
      OP_SUB = 4'h4,
      OP_AND = 4'h5,
      OP_OR  = 4'h6,
      OP_XOR = 4'h7,
      OP_NOT = 4'h8,
      OP_SHL = 4'h9,
      OP_SHR = 4'hA,
      OP_JMP = 4'hB,
      OP_JZ  = 4'hC,
      OP_JC  = 4'hD,
      OP_JN  = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   // Instructions whose result lands in ACC and therefore update ZF/NF.
   function automatic logic op_writes_acc(input opcode_e op);
      return op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR,
                        OP_XOR, OP_NOT, OP_SHL, OP_SHR};
   endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU for the accumulator CPU. Carry passes through unchanged
// for every operation that does not define its own carry.
module acc_alu
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  opcode_e           op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              cf_i,
   output logic [DATA_W-1:0] res_o,
   output logic              cf_o
);

   always_comb begin
      res_o = a_i;
      cf_o  = cf_i;
      case (op_i)
         OP_LDA: res_o = b_i;
         OP_ADD: {cf_o, res_o} = {1'b0, a_i} + {1'b0, b_i};
         // The extra top bit of the widened difference is the borrow.
         OP_SUB: {cf_o, res_o} = {1'b0, a_i} - {1'b0, b_i};
         OP_AND: res_o = a_i & b_i;
         OP_OR:  res_o = a_i | b_i;
         OP_XOR: res_o = a_i ^ b_i;
         OP_NOT: res_o = ~a_i;
         OP_SHL: begin
            res_o = {a_i[DATA_W-2:0], 1'b0};
            cf_o  = a_i[DATA_W-1];
         end
         OP_SHR: begin
            res_o = {1'b0, a_i[DATA_W-1:1]};
            cf_o  = a_i[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/acc_cpu_core.sv
// Two-cycle-per-instruction accumulator CPU: FETCH latches IR and bumps PC,
// EXEC performs the instruction; HLT parks the FSM until reset.
module acc_cpu_core
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic [ADDR_W-1:0] im_addr,
   input  logic [DATA_W-1:0] im_rdata,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic              dm_we,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic [DATA_W-1:0] acc_out,
   output logic [DATA_W-1:0] ir_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              zf,
   output logic              cf,
   output logic              nf,
   output logic              halted
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              zf_q, zf_d;
   logic              cf_q, cf_d;
   logic              nf_q, nf_d;

   opcode_e           op;
   logic [ADDR_W-1:0] opnd_addr;
   logic [DATA_W-1:0] alu_res;
   logic              alu_cf;

   assign op        = opcode_e'(ir_q[DATA_W-1 -: 4]);
   assign opnd_addr = ir_q[ADDR_W-1:0];

   acc_alu #(.DATA_W(DATA_W)) u_alu (
      .op_i  (op),
      .a_i   (acc_q),
      .b_i   (dm_rdata),
      .cf_i  (cf_q),
      .res_o (alu_res),
      .cf_o  (alu_cf)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      zf_d    = zf_q;
      cf_d    = cf_q;
      nf_d    = nf_q;
      dm_we   = 1'b0;
      if (run) begin
         case (state_q)
            ST_FETCH: begin
               ir_d    = im_rdata;
               pc_d    = pc_q + 1'b1;
               state_d = ST_EXEC;
            end
            ST_EXEC: begin
               state_d = ST_FETCH;
               cf_d    = alu_cf;
               if (op_writes_acc(op)) begin
                  acc_d = alu_res;
                  zf_d  = (alu_res == '0);
                  nf_d  = alu_res[DATA_W-1];
               end
               // Conditional jumps test the flags as they were when EXEC began.
               case (op)
                  OP_STA: dm_we = 1'b1;
                  OP_JMP: pc_d = opnd_addr;
                  OP_JZ:  if (zf_q) pc_d = opnd_addr;
                  OP_JC:  if (cf_q) pc_d = opnd_addr;
                  OP_JN:  if (nf_q) pc_d = opnd_addr;
                  OP_HLT: state_d = ST_HALT;
                  default: ;
               endcase
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         zf_q    <= 1'b0;
         cf_q    <= 1'b0;
         nf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         zf_q    <= zf_d;
         cf_q    <= cf_d;
         nf_q    <= nf_d;
      end
   end

   assign im_addr  = pc_q;
   assign dm_addr  = opnd_addr;
   assign dm_wdata = acc_q;
   assign acc_out  = acc_q;
   assign ir_out   = ir_q;
   assign pc_out   = pc_q;
   assign zf       = zf_q;
   assign cf       = cf_q;
   assign nf       = nf_q;
   assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: a 16/5 core and a 32/8 core, each with
// behavioural instruction/data memories, checked through a scoreboard queue.
module tb_acc_cpu_core;
   import acc_cpu_pkg::*;

   localparam int DW  = 16;
   localparam int AW  = 5;
   localparam int DWB = 32;
   localparam int AWB = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic run = 1'b0;
   logic run_b = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] im_addr, dm_addr, pc_out;
   logic [DW-1:0] im_rdata, dm_rdata, dm_wdata, acc_out, ir_out;
   logic          dm_we, zf, cf, nf, halted;

   logic [AWB-1:0] im_addr_b, dm_addr_b, pc_out_b;
   logic [DWB-1:0] im_rdata_b, dm_rdata_b, dm_wdata_b, acc_out_b, ir_out_b;
   logic           dm_we_b, zf_b, cf_b, nf_b, halted_b;

   logic [DW-1:0]  imem   [0:31];
   logic [DW-1:0]  dmem   [0:31];
   logic [DWB-1:0] imem_b [0:255];
   logic [DWB-1:0] dmem_b [0:255];

   assign im_rdata   = imem[im_addr];
   assign dm_rdata   = dmem[dm_addr];
   assign im_rdata_b = imem_b[im_addr_b];
   assign dm_rdata_b = dmem_b[dm_addr_b];

   acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .run(run),
      .im_addr(im_addr), .im_rdata(im_rdata),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
      .acc_out(acc_out), .ir_out(ir_out), .pc_out(pc_out),
      .zf(zf), .cf(cf), .nf(nf), .halted(halted)
   );

   acc_cpu_core #(.DATA_W(DWB), .ADDR_W(AWB)) dut_b (
      .clk(clk), .rst(rst), .run(run_b),
      .im_addr(im_addr_b), .im_rdata(im_rdata_b),
      .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b), .dm_we(dm_we_b), .dm_rdata(dm_rdata_b),
      .acc_out(acc_out_b), .ir_out(ir_out_b), .pc_out(pc_out_b),
      .zf(zf_b), .cf(cf_b), .nf(nf_b), .halted(halted_b)
   );

   // Data memories: preload restored while rst is high, writes logged on the strobe.
   int            wr_cnt = 0;
   int            wr_cnt_b = 0;
   logic [AW-1:0] obs_addr [0:63];
   logic [DW-1:0] obs_data [0:63];

   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) dmem[i] <= '0;
         dmem[3] <= 16'hFFFF;
         dmem[4] <= 16'h0001;
         dmem[5] <= 16'h00F0;
         dmem[6] <= 16'h0F0F;
         for (int i = 0; i < 256; i++) dmem_b[i] <= '0;
         dmem_b[1] <= 32'h8000_0000;
      end
      if (dm_we === 1'b1) begin
         dmem[dm_addr] <= dm_wdata;
         if (wr_cnt < 64) begin
            obs_addr[wr_cnt] <= dm_addr;
            obs_data[wr_cnt] <= dm_wdata;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (dm_we_b === 1'b1) begin
         dmem_b[dm_addr_b] <= dm_wdata_b;
         wr_cnt_b <= wr_cnt_b + 1;
      end
   end

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t exp_q [$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic sb_check(input logic [63:0] obs);
      exp_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL sb_empty: observed %0h, expected no output", obs);
      end else begin
         e = exp_q.pop_front();
         chk(e.tag, obs, e.val);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rst_on();
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
   endtask

   task automatic rst_off();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pc"}, 64'(pc_out), 64'd0);
      chk({tag, "_ir"}, 64'(ir_out), 64'd0);
      chk({tag, "_acc"}, 64'(acc_out), 64'd0);
      chk({tag, "_flags"}, 64'({zf, cf, nf}), 64'd0);
      chk({tag, "_halted"}, 64'(halted), 64'd0);
      chk({tag, "_dm_we"}, 64'(dm_we), 64'd0);
   endtask

   function automatic logic [DW-1:0] ins(input logic [3:0] op, input logic [AW-1:0] a);
      return {op, 7'b0, a};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 32; i++) imem[i] = ins(OP_NOP, 5'd0);
   endtask

   task automatic branch(input string tag, input logic [DW-1:0] i0, input logic [DW-1:0] i1,
                         input logic [DW-1:0] i2, input int n, input logic [AW-1:0] exp_pc);
      clear_imem();
      imem[0] = i0;
      imem[1] = i1;
      imem[2] = i2;
      sb_push(tag, 64'(exp_pc));
      rst_on();
      rst_off();
      cyc(n);
      sb_check(64'(pc_out));
   endtask

   task automatic load_arith();
      clear_imem();
      imem[0] = ins(OP_LDA, 5'd3);
      imem[1] = ins(OP_ADD, 5'd4);
      imem[2] = ins(OP_SUB, 5'd4);
      imem[3] = ins(OP_AND, 5'd5);
      imem[4] = ins(OP_OR,  5'd6);
      imem[5] = ins(OP_XOR, 5'd5);
      imem[6] = ins(OP_NOT, 5'd0);
      imem[7] = ins(OP_SHL, 5'd0);
      imem[8] = ins(OP_SHR, 5'd0);
      imem[9] = ins(OP_JMP, 5'd9);
   endtask

   initial begin
      int base;
      clear_imem();
      for (int i = 0; i < 256; i++) imem_b[i] = '0;

      // Reset state and sequential fetch with PC wrap
      run = 1'b1;
      rst_on();
      chk_reset("rst0");
      rst_off();
      cyc(2);  chk("fetch_pc1", 64'(pc_out), 64'd1);
      cyc(2);  chk("fetch_pc2", 64'(pc_out), 64'd2);
      chk("fetch_im_addr", 64'(im_addr), 64'd2);
      cyc(58); chk("fetch_pc31", 64'(pc_out), 64'd31);
      cyc(2);  chk("fetch_wrap", 64'(pc_out), 64'd0);

      // ALU operations: expected {acc, zf, cf, nf} after each EXEC
      load_arith();
      sb_push("lda",  64'({16'hFFFF, 3'b001}));
      sb_push("add",  64'({16'h0000, 3'b110}));
      sb_push("sub",  64'({16'hFFFF, 3'b011}));
      sb_push("and",  64'({16'h00F0, 3'b010}));
      sb_push("or",   64'({16'h0FFF, 3'b010}));
      sb_push("xor",  64'({16'h0F0F, 3'b010}));
      sb_push("not",  64'({16'hF0F0, 3'b011}));
      sb_push("shl",  64'({16'hE1E0, 3'b011}));
      sb_push("shr",  64'({16'h70F0, 3'b000}));
      rst_on();
      rst_off();
      cyc(1);
      chk("ir_fetch", 64'(ir_out), 64'h1003);
      cyc(1);
      sb_check(64'({acc_out, zf, cf, nf}));
      for (int i = 0; i < 8; i++) begin
         cyc(2);
         sb_check(64'({acc_out, zf, cf, nf}));
      end
      chk("pc_after_shr", 64'(pc_out), 64'd9);
      cyc(2); chk("jmp_self_pc", 64'(pc_out), 64'd9);
      cyc(2); chk("jmp_self_pc2", 64'(pc_out), 64'd9);
      chk("jmp_self_acc", 64'(acc_out), 64'h70F0);

      // run=0 in the middle of EXEC freezes everything
      rst_on();
      rst_off();
      cyc(1);
      run = 1'b0;
      cyc(5);
      chk("freeze_pc", 64'(pc_out), 64'd1);
      chk("freeze_ir", 64'(ir_out), 64'h1003);
      chk("freeze_acc", 64'(acc_out), 64'h0);
      chk("freeze_halted", 64'(halted), 64'd0);
      run = 1'b1;
      cyc(1);
      chk("resume_acc", 64'(acc_out), 64'hFFFF);

      // Store: one strobe cycle, also suppressed while run=0
      clear_imem();
      imem[0] = ins(OP_LDA, 5'd3);
      imem[1] = ins(OP_STA, 5'd7);
      imem[2] = ins(OP_JMP, 5'd2);
      rst_on();
      rst_off();
      base = wr_cnt;
      sb_push("sta_addr", 64'd7);
      sb_push("sta_data", 64'hFFFF);
      cyc(3);
      chk("sta_we", 64'(dm_we), 64'd1);
      chk("sta_dm_addr", 64'(dm_addr), 64'd7);
      chk("sta_dm_wdata", 64'(dm_wdata), 64'hFFFF);
      run = 1'b0;
      #1 chk("sta_we_run0", 64'(dm_we), 64'd0);
      cyc(3);
      chk("sta_run0_nowrite", 64'(wr_cnt - base), 64'd0);
      run = 1'b1;
      cyc(3);
      chk("sta_we_after", 64'(dm_we), 64'd0);
      chk("sta_wr_count", 64'(wr_cnt - base), 64'd1);
      sb_check(64'(obs_addr[base]));
      sb_check(64'(obs_data[base]));
      chk("sta_dmem7", 64'(dmem[7]), 64'hFFFF);

      // Branches: taken / not-taken pairs
      branch("jz_taken",    ins(OP_LDA, 5'd8), ins(OP_JZ, 5'd10), ins(OP_NOP, 5'd0), 4, 5'd10);
      branch("jz_fall",     ins(OP_LDA, 5'd4), ins(OP_JZ, 5'd10), ins(OP_NOP, 5'd0), 4, 5'd2);
      branch("jn_taken",    ins(OP_LDA, 5'd3), ins(OP_JN, 5'd12), ins(OP_NOP, 5'd0), 4, 5'd12);
      branch("jn_fall",     ins(OP_LDA, 5'd4), ins(OP_JN, 5'd12), ins(OP_NOP, 5'd0), 4, 5'd2);
      branch("jc_taken",    ins(OP_LDA, 5'd3), ins(OP_ADD, 5'd4), ins(OP_JC, 5'd14), 6, 5'd14);
      branch("jc_fall",     ins(OP_LDA, 5'd4), ins(OP_ADD, 5'd4), ins(OP_JC, 5'd14), 6, 5'd3);

      // HLT parks the core; run is ignored there
      clear_imem();
      imem[0] = ins(OP_LDA, 5'd3);
      imem[1] = ins(OP_HLT, 5'd0);
      rst_on();
      rst_off();
      cyc(4);
      chk("hlt_halted", 64'(halted), 64'd1);
      chk("hlt_pc", 64'(pc_out), 64'd2);
      run = 1'b0;
      cyc(1);
      run = 1'b1;
      cyc(6);
      chk("hlt_still_halted", 64'(halted), 64'd1);
      chk("hlt_pc_frozen", 64'(pc_out), 64'd2);
      chk("hlt_acc", 64'(acc_out), 64'hFFFF);

      // Reset during STA EXEC aborts the write
      clear_imem();
      imem[0] = ins(OP_LDA, 5'd3);
      imem[1] = ins(OP_STA, 5'd9);
      rst_on();
      rst_off();
      base = wr_cnt;
      cyc(3);
      chk("rsta_we_before", 64'(dm_we), 64'd1);
      rst = 1'b1;
      #1;
      chk_reset("rsta");
      rst_off();
      chk("rsta_nowrite", 64'(wr_cnt - base), 64'd0);
      chk("rsta_dmem9", 64'(dmem[9]), 64'd0);
      cyc(1);
      chk("rsta_refetch_ir", 64'(ir_out), 64'h1003);
      chk("rsta_refetch_pc", 64'(pc_out), 64'd1);

      // 32-bit / 8-bit address core: SHL out of MSB and PC wrap at 255
      imem_b[0] = 32'h1000_0001;
      imem_b[1] = 32'h9000_0000;
      run_b = 1'b1;
      rst_on();
      rst_off();
      cyc(4);
      chk("w32_shl_acc", 64'(acc_out_b), 64'd0);
      chk("w32_shl_flags", 64'({zf_b, cf_b, nf_b}), 64'b110);
      chk("w32_pc2", 64'(pc_out_b), 64'd2);
      cyc(506);
      chk("w32_pc255", 64'(pc_out_b), 64'd255);
      cyc(2);
      chk("w32_wrap", 64'(pc_out_b), 64'd0);
      chk("w32_no_writes", 64'(wr_cnt_b), 64'd0);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/acc_cpu_core.md
ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, accumulator/data/instruction width (legal: >= ADDR_W+4).
REQ-002 SHALL have parameter ADDR_W, default 5, program-counter and data-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  input  1  1 = FSM advances; 0 = all state held.
REQ-006 SHALL have port im_addr  output  ADDR_W  instruction address (= PC).
REQ-007 SHALL have port im_rdata  input  DATA_W  instruction word, combinational read of im_addr.
REQ-008 SHALL have port dm_addr  output  ADDR_W  data address (= IR[ADDR_W-1:0]).
REQ-009 SHALL have port dm_wdata  output  DATA_W  store data (= ACC).
REQ-010 SHALL have port dm_we  output  1  one-cycle write strobe.
REQ-011 SHALL have port dm_rdata  input  DATA_W  operand, combinational read of dm_addr.
REQ-012 SHALL have ports acc_out (DATA_W), ir_out (DATA_W), pc_out (ADDR_W), zf, cf, nf, halted (1 each), all outputs, registered state.

Function
REQ-013 Instruction format SHALL be opcode = IR[DATA_W-1:DATA_W-4], operand address = IR[ADDR_W-1:0]; remaining bits ignored.
REQ-014 Opcodes SHALL be: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 SHL, A SHR, B JMP, C JZ, D JC, E JN, F HLT.
REQ-015 FSM SHALL have states FETCH, EXEC, HALT; FETCH->EXEC, EXEC->FETCH (EXEC->HALT on HLT); HALT absorbing until reset.
REQ-016 FETCH SHALL latch IR <= im_rdata and PC <= PC+1 modulo 2^ADDR_W (wrap all-ones -> 0).
REQ-017 EXEC SHALL perform the opcode; each instruction takes exactly 2 enabled cycles.
REQ-018 LDA/ADD/SUB/AND/OR/XOR SHALL use dm_rdata as operand; NOT/SHL/SHR operate on ACC only; result written to ACC at end of EXEC.
REQ-019 ADD: CF = carry out; SUB (ACC-operand): CF = borrow (ACC < operand unsigned); SHL: CF = old ACC MSB; SHR (logical): CF = old ACC LSB; other ops leave CF unchanged.
REQ-020 Every ACC-writing op SHALL set ZF = (result==0) and NF = result MSB; STA, jumps, NOP, HLT leave all flags unchanged.
REQ-021 STA SHALL assert dm_we for exactly the EXEC cycle; dm_we SHALL be 0 in all other cycles, in HALT, and when run=0.
REQ-022 JMP SHALL load PC <= operand address; JZ/JC/JN SHALL do so only if ZF/CF/NF (flag value at EXEC start) is 1, else PC unchanged.
REQ-023 A jump to the current PC value SHALL be legal (tight loop).
REQ-024 When run=0 SHALL hold PC, IR, ACC, flags, state; resuming continues in the held state.
REQ-025 halted SHALL be 1 iff state = HALT; in HALT run is ignored.

Reset
REQ-026 On rst=1 (asynchronous) SHALL set PC=0, IR=0, ACC=0, zf=cf=nf=0, halted=0, state=FETCH, dm_we=0, regardless of run or state.
REQ-027 Reset asserted mid-instruction SHALL abort it with no data-memory write; first fetch after release SHALL be address 0.

Structure
REQ-028 Opcode constants and FSM state encoding SHALL live in shared package acc_cpu_pkg.
REQ-029 Combinational ALU (result, carry) SHALL be sub-module acc_alu, parameterised by DATA_W; FSM, PC, IR, ACC, flags in acc_cpu_core.

Verification
REQ-030 Reset/fetch: rst pulse, run=1, memory all NOP -> pc_out 0,1,2 every 2 cycles; wraps 31->0 (ADDR_W=5).
REQ-031 Arithmetic: DM[3]=0xFFFF, DM[4]=0x0001; LDA 3, ADD 4 -> acc 0x0000, zf=1, cf=1, nf=0; SUB 4 -> acc 0xFFFF, cf=1, nf=1.
REQ-032 Store: LDA 3, STA 7 -> dm_we high exactly one cycle, dm_addr=7, dm_wdata=0xFFFF; DM[7]=0xFFFF.
REQ-033 Branches: acc=0 then JZ 10 -> pc 10; acc=1 then JZ 10 -> fall through; JN, JC taken/not-taken pairs; JMP to self loops.
REQ-034 Control: run=0 for 5 cycles mid-EXEC -> all outputs frozen; HLT -> halted=1, pc frozen; rst during STA EXEC -> no write, all outputs reset values.
REQ-035 Parameters: DATA_W=32, ADDR_W=8 -> SHL of 0x80000000 gives acc 0, cf=1, zf=1; PC wraps 255->0.
